// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte master: FSM state encoding and SPI mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_byte_master_if.sv
// Parallel word interface between the core and the SPI byte master.
interface spi_byte_master_if #(
  parameter int WIDTH = 8
) ();

  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             busy;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_valid,
    input  rx_data,
    input  busy
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_valid,
    output rx_data,
    output busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period divider for the SPI master: phase_end every CLK_DIV cycles while enabled,
// plus rise/fall strobes that alternate during the shift phase.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift,
  output logic phase_end,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;

  assign phase_end = en && (cnt_r == CNT_W'(CLK_DIV - 1));
  assign rise      = phase_end && shift && !phase_r;
  assign fall      = phase_end && shift && phase_r;

  // Divider counter and sclk phase tracker; phase_r mirrors the level sclk is about to leave.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (!en) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (phase_end) begin
      cnt_r   <= '0;
      phase_r <= shift ? !phase_r : 1'b0;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// SPI mode-0 master: one WIDTH-bit word per transaction, MSB first, with registered pin outputs.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_byte_master_if.slave   bus,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic               cs_n
);

  localparam int BIT_W = $clog2(WIDTH + 1);

  state_t           state_r;
  logic [WIDTH-1:0] tx_shift_r;
  logic [WIDTH-1:0] rx_shift_r;
  logic [WIDTH-1:0] rx_data_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic             sclk_r;
  logic             mosi_r;
  logic             cs_n_r;
  logic             rx_valid_r;
  logic             tx_ready_r;
  logic             busy_r;

  logic             en_s;
  logic             shift_s;
  logic             last_bit_s;
  logic             phase_end_s;
  logic             rise_s;
  logic             fall_s;

  assign en_s       = (state_r != ST_IDLE);
  assign shift_s    = (state_r == ST_SHIFT);
  assign last_bit_s = (bit_cnt_r == BIT_W'(WIDTH - 1));

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (en_s),
    .shift     (shift_s),
    .phase_end (phase_end_s),
    .rise      (rise_s),
    .fall      (fall_s)
  );

  // Transaction FSM with shift registers and all pin/bus outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tx_shift_r <= '0;
      rx_shift_r <= '0;
      rx_data_r  <= '0;
      bit_cnt_r  <= '0;
      sclk_r     <= SPI_CPOL;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      rx_valid_r <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.tx_valid && tx_ready_r) begin
            state_r    <= ST_SETUP;
            tx_shift_r <= bus.tx_data;
            mosi_r     <= bus.tx_data[WIDTH-1];
            cs_n_r     <= 1'b0;
            tx_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            bit_cnt_r  <= '0;
          end
        end
        ST_SETUP: begin
          if (phase_end_s) begin
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise_s) begin
            sclk_r     <= 1'b1;
            rx_shift_r <= {rx_shift_r[WIDTH-2:0], miso};
          end else if (fall_s) begin
            sclk_r <= 1'b0;
            // The last falling edge leaves mosi on the final bit through HOLD.
            if (last_bit_s) begin
              state_r   <= ST_HOLD;
              bit_cnt_r <= '0;
            end else begin
              bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
              tx_shift_r <= {tx_shift_r[WIDTH-2:0], 1'b0};
              mosi_r     <= tx_shift_r[WIDTH-2];
            end
          end
        end
        ST_HOLD: begin
          if (phase_end_s) begin
            state_r    <= ST_IDLE;
            cs_n_r     <= 1'b1;
            mosi_r     <= 1'b0;
            rx_valid_r <= 1'b1;
            rx_data_r  <= rx_shift_r;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk         = sclk_r;
  assign mosi         = mosi_r;
  assign cs_n         = cs_n_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.busy     = busy_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_data  = rx_data_r;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: one instance with CLK_DIV=2, one with CLK_DIV=1.
module tb_spi_byte_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       tv;
  logic [7:0] td;
  logic [1:0] mm;

  always #5 clk = ~clk;

  spi_byte_master_if #(.WIDTH(8)) if0 ();
  spi_byte_master_if #(.WIDTH(8)) if1 ();

  logic sclk0, mosi0, miso0, cs_n0;
  logic sclk1, mosi1, miso1, cs_n1;

  assign if0.tx_valid = tv & ~sel;
  assign if1.tx_valid = tv & sel;
  assign if0.tx_data  = td;
  assign if1.tx_data  = td;
  assign miso0 = (mm == 2'd2) ? mosi0 : mm[0];
  assign miso1 = (mm == 2'd2) ? mosi1 : mm[0];

  spi_byte_master #(.WIDTH(8), .CLK_DIV(2)) dut0 (
    .clk (clk), .rst (rst), .bus (if0),
    .sclk (sclk0), .mosi (mosi0), .miso (miso0), .cs_n (cs_n0)
  );

  spi_byte_master #(.WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1),
    .sclk (sclk1), .mosi (mosi1), .miso (miso1), .cs_n (cs_n1)
  );

  logic       cur_sclk, cur_mosi, cur_cs_n, cur_ready, cur_busy, cur_rx_valid;
  logic [7:0] cur_rx_data;
  assign cur_sclk     = sel ? sclk1 : sclk0;
  assign cur_mosi     = sel ? mosi1 : mosi0;
  assign cur_cs_n     = sel ? cs_n1 : cs_n0;
  assign cur_ready    = sel ? if1.tx_ready : if0.tx_ready;
  assign cur_busy     = sel ? if1.busy : if0.busy;
  assign cur_rx_valid = sel ? if1.rx_valid : if0.rx_valid;
  assign cur_rx_data  = sel ? if1.rx_data : if0.rx_data;

  int checks   = 0;
  int failures = 0;

  int         r_k, r_rises, r_gap;
  logic [7:0] r_pat, r_rx;
  logic       r_cs1, r_rdy1, r_rdyrx, r_csrx, r_early, r_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the handshake posedge; cycle k is sampled at the k-th following negedge.
  task automatic wait_rx(input int mode, input logic [7:0] nd);
    logic prev;
    int   first_rise;
    prev = 1'b0; first_rise = 0;
    r_k = 0; r_rises = 0; r_gap = 0; r_pat = 8'h00; r_rx = 8'h00;
    r_cs1 = 1'b0; r_rdy1 = 1'b0; r_rdyrx = 1'b0; r_csrx = 1'b0; r_early = 1'b0; r_bad = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        r_cs1  = cur_cs_n;
        r_rdy1 = cur_ready;
      end
      if (cur_sclk && !prev) begin
        r_rises++;
        r_pat = {r_pat[6:0], cur_mosi};
        if (r_rises == 1) first_rise = k;
        else if (r_rises == 2) r_gap = k - first_rise;
      end
      prev = cur_sclk;
      if (cur_sclk && cur_cs_n) r_bad = 1'b1;
      if (cur_rx_valid) begin
        r_k     = k;
        r_rx    = cur_rx_data;
        r_rdyrx = cur_ready;
        r_csrx  = cur_cs_n;
      end else if (cur_ready) begin
        r_early = 1'b1;
      end
      case (mode)
        0: if (k == 1) tv = 1'b0;
        1: if (k == 1) td = nd;
        default: begin
          if (cur_ready) tv = 1'b0;
          else begin
            tv = ~tv;
            td = 8'hFF;
          end
        end
      endcase
      if (cur_rx_valid) break;
    end
  endtask

  task automatic xfer(input logic s, input logic [1:0] miso_mode, input logic [7:0] data,
                      input int mode, input logic [7:0] exp_rx, input int exp_lat,
                      input int exp_gap, input string tag);
    @(negedge clk);
    sel = s;
    mm  = miso_mode;
    chk({tag, "_ready_before"}, cur_ready, 1);
    tv = 1'b1;
    td = data;
    @(posedge clk);
    wait_rx(mode, 8'h00);
    chk({tag, "_latency"}, r_k, exp_lat);
    chk({tag, "_sclk_rises"}, r_rises, 8);
    chk({tag, "_mosi_pattern"}, r_pat, data);
    chk({tag, "_rx_data"}, r_rx, exp_rx);
    chk({tag, "_sclk_period"}, r_gap, exp_gap);
    chk({tag, "_ready_at_rx"}, r_rdyrx, 1);
    chk({tag, "_cs_n_at_rx"}, r_csrx, 1);
    chk({tag, "_ready_early"}, r_early, 0);
    chk({tag, "_sclk_without_cs"}, r_bad, 0);
  endtask

  initial begin
    int   n;
    int   nrx;
    logic prev;
    rst = 1'b1; sel = 1'b0; tv = 1'b0; td = 8'h00; mm = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cs_n", cs_n0, 1);
    chk("reset_sclk", sclk0, 0);
    chk("reset_mosi", mosi0, 0);
    chk("reset_rx_valid", if0.rx_valid, 0);
    chk("reset_rx_data", if0.rx_data, 8'h00);
    chk("reset_tx_ready", if0.tx_ready, 1);
    chk("reset_busy", if0.busy, 0);
    rst = 1'b0;

    xfer(1'b0, 2'd2, 8'hA5, 0, 8'hA5, 37, 4, "t1_loop_a5");
    xfer(1'b0, 2'd1, 8'h00, 0, 8'hFF, 37, 4, "t2_miso1");
    xfer(1'b0, 2'd0, 8'hFF, 0, 8'h00, 37, 4, "t2_miso0");

    // Back-to-back: tx_valid stays high, data switches to the second word after the first handshake.
    @(negedge clk);
    sel = 1'b0; mm = 2'd2;
    tv = 1'b1; td = 8'h3C;
    @(posedge clk);
    wait_rx(1, 8'hC3);
    chk("t3_first_latency", r_k, 37);
    chk("t3_first_rx", r_rx, 8'h3C);
    chk("t3_first_ready_at_rx", r_rdyrx, 1);
    @(posedge clk);
    wait_rx(0, 8'h00);
    chk("t3_cs_n_gap_one_cycle", r_cs1, 0);
    chk("t3_ready_after_second", r_rdy1, 0);
    chk("t3_second_latency", r_k, 37);
    chk("t3_second_rx", r_rx, 8'hC3);
    chk("t3_second_pattern", r_pat, 8'hC3);

    // Reset one cycle after the third sclk rise.
    @(negedge clk);
    sel = 1'b0; mm = 2'd2;
    tv = 1'b1; td = 8'hF0;
    @(posedge clk);
    n = 0; prev = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) tv = 1'b0;
      if (cur_sclk && !prev) n++;
      prev = cur_sclk;
      if (n == 3) break;
    end
    chk("t4_third_rise_seen", n, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_cs_n", cs_n0, 1);
    chk("t4_sclk", sclk0, 0);
    chk("t4_mosi", mosi0, 0);
    chk("t4_tx_ready", if0.tx_ready, 1);
    chk("t4_rx_valid", if0.rx_valid, 0);
    chk("t4_rx_data_cleared", if0.rx_data, 8'h00);
    nrx = 0;
    repeat (40) begin
      @(negedge clk);
      if (if0.rx_valid) nrx++;
    end
    chk("t4_no_rx_valid", nrx, 0);
    xfer(1'b0, 2'd2, 8'h5A, 0, 8'h5A, 37, 4, "t4_after_reset");

    xfer(1'b0, 2'd2, 8'h81, 2, 8'h81, 37, 4, "t5_busy_noise");

    xfer(1'b1, 2'd2, 8'h96, 0, 8'h96, 19, 2, "t6_div1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
